// File: rtl/modo_libre_multinota.sv
// Free-play note FSM: maps held ASCII keys KEY_BASE..KEY_BASE+NUM_NOTES-1 to note
// indices, enforces a minimum sound time and reports each finished note and its length.
module modo_libre_multinota #(
    parameter int         NUM_NOTES = 4,
    parameter int         NOTE_W    = 3,
    parameter logic [7:0] KEY_BASE  = 8'd97,
    parameter int         MIN_HOLD  = 4,
    parameter int         DUR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inicio,
    input  logic              fin,
    input  logic [7:0]        entrada,
    output logic [NOTE_W-1:0] notaSalida,
    output logic              contar,
    output logic [DUR_W-1:0]  duracion,
    output logic              nota_fin,
    output logic [NOTE_W-1:0] nota_fin_id,
    output logic [DUR_W-1:0]  nota_fin_dur
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ESPERA  = 2'd1,
        SONANDO = 2'd2,
        SOSTEN  = 2'd3
    } estado_t;

    localparam logic [7:0]       KEY_LAST = KEY_BASE + 8'(NUM_NOTES - 1);
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;
    localparam logic [DUR_W-1:0] HOLD     = DUR_W'(MIN_HOLD);
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

    estado_t           estado, estado_sig;
    logic [NOTE_W-1:0] nota_sig, fin_id_sig, tecla_id;
    logic [DUR_W-1:0]  dur_sig, fin_dur_sig, dur_inc;
    logic              contar_sig, fin_sig, terminar, tecla_valida;
    logic [7:0]        offset;

    always_comb begin
        offset       = entrada - KEY_BASE;
        tecla_valida = (entrada >= KEY_BASE) && (entrada <= KEY_LAST);
        tecla_id     = NOTE_W'(offset + 8'd1);
        dur_inc      = (duracion == DUR_MAX) ? duracion : duracion + DUR_ONE;
    end

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        estado_sig = estado;
        nota_sig   = notaSalida;
        contar_sig = contar;
        dur_sig    = duracion;
        terminar   = 1'b0;

        case (estado)
            IDLE: begin
                nota_sig   = '0;
                contar_sig = 1'b0;
                dur_sig    = '0;
                if (inicio) estado_sig = ESPERA;
            end
            ESPERA: begin
                nota_sig   = '0;
                contar_sig = 1'b0;
                dur_sig    = '0;
                if (fin) begin
                    estado_sig = IDLE;
                end else if (tecla_valida) begin
                    estado_sig = SONANDO;
                    nota_sig   = tecla_id;
                    contar_sig = 1'b1;
                    dur_sig    = DUR_ONE;
                end
            end
            SONANDO, SOSTEN: begin
                if (fin) begin
                    estado_sig = IDLE;
                    terminar   = 1'b1;
                    nota_sig   = '0;
                    contar_sig = 1'b0;
                    dur_sig    = '0;
                end else if (tecla_valida && tecla_id == notaSalida) begin
                    estado_sig = SONANDO;
                    dur_sig    = dur_inc;
                end else if (tecla_valida) begin
                    // Direct switch: the new note starts on the same edge, no silent gap.
                    estado_sig = SONANDO;
                    terminar   = 1'b1;
                    nota_sig   = tecla_id;
                    dur_sig    = DUR_ONE;
                end else if (duracion >= HOLD) begin
                    estado_sig = ESPERA;
                    terminar   = 1'b1;
                    nota_sig   = '0;
                    contar_sig = 1'b0;
                    dur_sig    = '0;
                end else begin
                    estado_sig = SOSTEN;
                    dur_sig    = dur_inc;
                end
            end
            default: begin
                estado_sig = IDLE;
                nota_sig   = '0;
                contar_sig = 1'b0;
                dur_sig    = '0;
            end
        endcase

        fin_sig     = terminar;
        fin_id_sig  = terminar ? notaSalida : nota_fin_id;
        fin_dur_sig = terminar ? duracion   : nota_fin_dur;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, matching the end-of-note report of the value before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= IDLE;
            notaSalida   <= '0;
            contar       <= 1'b0;
            duracion     <= '0;
            nota_fin     <= 1'b0;
            nota_fin_id  <= '0;
            nota_fin_dur <= '0;
        end else begin
            estado       <= estado_sig;
            notaSalida   <= nota_sig;
            contar       <= contar_sig;
            duracion     <= dur_sig;
            nota_fin     <= fin_sig;
            nota_fin_id  <= fin_id_sig;
            nota_fin_dur <= fin_dur_sig;
        end
    end

endmodule

// File: tb/tb_modo_libre_multinota.sv
// Bench for modo_libre_multinota: three configurations share one stimulus stream and
// are compared every cycle against a note-level reference model.
module tb_modo_libre_multinota;

    localparam int NI = 3;
    localparam int MIN_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic       fin = 1'b0;
    logic [7:0] entrada = 8'd0;

    logic [2:0]  o_nota    [NI];
    logic        o_contar  [NI];
    logic [15:0] o_dur     [NI];
    logic        o_fin     [NI];
    logic [2:0]  o_fin_id  [NI];
    logic [15:0] o_fin_dur [NI];
    logic [3:0]  dur_small, fin_dur_small;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: seven notes. Instance 2: 4-bit duration.
    modo_libre_multinota dut0 (
        .clk(clk), .reset(reset), .inicio(inicio), .fin(fin), .entrada(entrada),
        .notaSalida(o_nota[0]), .contar(o_contar[0]), .duracion(o_dur[0]),
        .nota_fin(o_fin[0]), .nota_fin_id(o_fin_id[0]), .nota_fin_dur(o_fin_dur[0]));

    modo_libre_multinota #(.NUM_NOTES(7)) dut1 (
        .clk(clk), .reset(reset), .inicio(inicio), .fin(fin), .entrada(entrada),
        .notaSalida(o_nota[1]), .contar(o_contar[1]), .duracion(o_dur[1]),
        .nota_fin(o_fin[1]), .nota_fin_id(o_fin_id[1]), .nota_fin_dur(o_fin_dur[1]));

    modo_libre_multinota #(.DUR_W(4)) dut2 (
        .clk(clk), .reset(reset), .inicio(inicio), .fin(fin), .entrada(entrada),
        .notaSalida(o_nota[2]), .contar(o_contar[2]), .duracion(dur_small),
        .nota_fin(o_fin[2]), .nota_fin_id(o_fin_id[2]), .nota_fin_dur(fin_dur_small));

    assign o_dur[2]     = {12'd0, dur_small};
    assign o_fin_dur[2] = {12'd0, fin_dur_small};

    // Reference model: armed flag, sounding note (0 = silence) and its length.
    int n_notes [NI] = '{4, 7, 4};
    int dur_max [NI] = '{65535, 65535, 15};
    bit m_armed [NI];
    int m_note [NI], m_dur [NI], m_fin_id [NI], m_fin_dur [NI];
    bit m_fin [NI];

    task automatic model_end(input int i);
        m_fin[i]     = 1'b1;
        m_fin_id[i]  = m_note[i];
        m_fin_dur[i] = m_dur[i];
    endtask

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            int k;
            k = (entrada >= 8'd97 && int'(entrada) < 97 + n_notes[i]) ? int'(entrada) - 96 : 0;
            if (reset) begin
                m_armed[i] = 0; m_note[i] = 0; m_dur[i] = 0;
                m_fin[i] = 0; m_fin_id[i] = 0; m_fin_dur[i] = 0;
            end else begin
                m_fin[i] = 0;
                if (!m_armed[i]) begin
                    if (inicio) m_armed[i] = 1;
                end else if (m_note[i] == 0) begin
                    if (fin) m_armed[i] = 0;
                    else if (k != 0) begin m_note[i] = k; m_dur[i] = 1; end
                end else if (fin) begin
                    model_end(i); m_armed[i] = 0; m_note[i] = 0; m_dur[i] = 0;
                end else if (k == m_note[i]) begin
                    m_dur[i] = (m_dur[i] < dur_max[i]) ? m_dur[i] + 1 : m_dur[i];
                end else if (k != 0) begin
                    model_end(i); m_note[i] = k; m_dur[i] = 1;
                end else if (m_dur[i] >= MIN_HOLD) begin
                    model_end(i); m_note[i] = 0; m_dur[i] = 0;
                end else begin
                    m_dur[i] = m_dur[i] + 1;
                end
            end
        end
    endtask

    always @(posedge clk) model_update();

    function automatic logic [39:0] obs(input int i);
        return {o_nota[i], o_contar[i], o_dur[i], o_fin[i], o_fin_id[i], o_fin_dur[i]};
    endfunction

    function automatic logic [39:0] expv(input int i);
        return {3'(m_note[i]), m_note[i] != 0, 16'(m_dur[i]), m_fin[i],
                3'(m_fin_id[i]), 16'(m_fin_dur[i])};
    endfunction

    task automatic tick(input logic [7:0] key, input logic ini, input logic f);
        entrada = key; inicio = ini; fin = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(8'd97, 1'b1, 1'b1);
        tick(8'd97, 1'b1, 1'b1);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== 40'd0) begin
                failures++;
                $display("FAIL reset inst%0d got=%h exp=%h", i, obs(i), 40'd0);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(8'd97, 1'b0, 1'b0);
            checks++;
            if (o_nota[0] !== 3'd0 || o_contar[0] !== 1'b0) begin
                failures++;
                $display("FAIL idle_ignores_key got=%0d/%0d exp=0/0", o_nota[0], o_contar[0]);
            end
        end
    endtask

    task automatic test_long_note();
        tick(8'd0, 1'b1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick(8'd98, 1'b0, 1'b0);
            checks++;
            if (o_nota[0] !== 3'd2 || o_dur[0] !== 16'(c)) begin
                failures++;
                $display("FAIL long_note got=%0d dur=%0d exp=2 dur=%0d", o_nota[0], o_dur[0], c);
            end
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL long_note_model inst%0d got=%h exp=%h", i, obs(i), expv(i));
                end
            end
        end
        tick(8'd0, 1'b0, 1'b0);
        checks++;
        if ({o_nota[0], o_fin[0], o_fin_id[0], o_fin_dur[0]} !== {3'd0, 1'b1, 3'd2, 16'd10}) begin
            failures++;
            $display("FAIL long_note_end got nota=%0d fin=%0d id=%0d dur=%0d exp 0 1 2 10",
                     o_nota[0], o_fin[0], o_fin_id[0], o_fin_dur[0]);
        end
    endtask

    task automatic test_tap();
        int sounding;
        bit fin_ok;
        sounding = 0;
        fin_ok = 1'b0;
        tick(8'd99, 1'b0, 1'b0);
        if (o_nota[0] == 3'd3 && o_contar[0]) sounding++;
        for (int c = 0; c < 6; c++) begin
            tick(8'd0, 1'b0, 1'b0);
            if (o_nota[0] == 3'd3 && o_contar[0]) sounding++;
            else if (c == 3 && o_fin[0] && o_fin_id[0] == 3'd3 && o_fin_dur[0] == 16'd4) fin_ok = 1'b1;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL tap_model inst%0d got=%h exp=%h", i, obs(i), expv(i));
                end
            end
        end
        checks++;
        if (sounding != MIN_HOLD || !fin_ok) begin
            failures++;
            $display("FAIL tap got cycles=%0d end_ok=%0d exp cycles=4 end_ok=1", sounding, fin_ok);
        end
    endtask

    task automatic test_switch();
        int gaps;
        gaps = 0;
        for (int c = 0; c < 14; c++) begin
            tick(c < 5 ? 8'd97 : (c < 8 ? 8'd100 : 8'd0), 1'b0, 1'b0);
            if (c < 8 && o_contar[0] !== 1'b1) gaps++;
            if (c == 5) begin
                checks++;
                if ({o_nota[0], o_fin[0], o_fin_id[0], o_fin_dur[0]} !== {3'd4, 1'b1, 3'd1, 16'd5}) begin
                    failures++;
                    $display("FAIL switch_end got nota=%0d fin=%0d id=%0d dur=%0d exp 4 1 1 5",
                             o_nota[0], o_fin[0], o_fin_id[0], o_fin_dur[0]);
                end
            end
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL switch_model inst%0d got=%h exp=%h", i, obs(i), expv(i));
                end
            end
        end
        checks++;
        if (gaps != 0 || o_fin_id[0] !== 3'd4 || o_fin_dur[0] !== 16'd4) begin
            failures++;
            $display("FAIL switch got gaps=%0d id=%0d dur=%0d exp gaps=0 id=4 dur=4",
                     gaps, o_fin_id[0], o_fin_dur[0]);
        end
    endtask

    task automatic test_range();
        logic [7:0] keys [6] = '{8'd96, 8'd101, 8'd0, 8'd103, 8'd0, 8'd0};
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick(keys[s], 1'b0, 1'b0);
                checks++;
                if (o_nota[0] !== 3'd0) begin
                    failures++;
                    $display("FAIL range_inst0 key=%0d got=%0d exp=0", keys[s], o_nota[0]);
                end
                if (s == 3 && c == 0) begin
                    checks++;
                    if (o_nota[1] !== 3'd7) begin
                        failures++;
                        $display("FAIL range_note7 got=%0d exp=7", o_nota[1]);
                    end
                end
                for (int i = 0; i < NI; i++) begin
                    checks++;
                    if (obs(i) !== expv(i)) begin
                        failures++;
                        $display("FAIL range_model inst%0d got=%h exp=%h", i, obs(i), expv(i));
                    end
                end
            end
        end
    endtask

    task automatic test_fin();
        for (int c = 0; c < 6; c++) tick(8'd98, 1'b0, 1'b0);
        tick(8'd98, 1'b0, 1'b1);
        checks++;
        if ({o_nota[0], o_contar[0], o_fin[0], o_fin_id[0], o_fin_dur[0]} !==
            {3'd0, 1'b0, 1'b1, 3'd2, 16'd6}) begin
            failures++;
            $display("FAIL fin_end got nota=%0d contar=%0d fin=%0d id=%0d dur=%0d exp 0 0 1 2 6",
                     o_nota[0], o_contar[0], o_fin[0], o_fin_id[0], o_fin_dur[0]);
        end
        for (int c = 0; c < 5; c++) begin
            tick(8'd97, 1'b0, 1'b0);
            checks++;
            if (o_nota[0] !== 3'd0 || o_fin[0] !== 1'b0) begin
                failures++;
                $display("FAIL fin_idle got nota=%0d fin=%0d exp 0 0", o_nota[0], o_fin[0]);
            end
        end
    endtask

    task automatic test_saturate_and_reset();
        tick(8'd0, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) tick(8'd97, 1'b0, 1'b0);
        checks++;
        if (o_dur[2] !== 16'd15 || o_dur[0] !== 16'd20) begin
            failures++;
            $display("FAIL saturate got dur4=%0d dur16=%0d exp 15 20", o_dur[2], o_dur[0]);
        end
        tick(8'd0, 1'b0, 1'b0);
        checks++;
        if (o_fin[2] !== 1'b1 || o_fin_dur[2] !== 16'd15) begin
            failures++;
            $display("FAIL saturate_end got fin=%0d dur=%0d exp 1 15", o_fin[2], o_fin_dur[2]);
        end
        for (int c = 0; c < 3; c++) tick(8'd98, 1'b0, 1'b0);
        reset = 1'b1;
        tick(8'd98, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs(i) !== 40'd0) begin
                failures++;
                $display("FAIL reset_mid_note inst%0d got=%h exp=%h", i, obs(i), 40'd0);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        logic [7:0] key;
        hold = 0;
        key = 8'd0;
        for (int c = 0; c < 1500; c++) begin
            int r;
            if (hold == 0) begin
                r = int'($urandom_range(0, 15));
                key = (r < 12) ? 8'(95 + r) : 8'd0;
                hold = int'($urandom_range(1, 8));
            end
            hold--;
            reset = ($urandom_range(0, 199) == 0);
            tick(key, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL random_model cyc%0d inst%0d got=%h exp=%h", c, i, obs(i), expv(i));
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_long_note();
        test_tap();
        test_switch();
        test_range();
        test_fin();
        test_saturate_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modo_libre_multinota.md
# modo_libre_multinota

Parametrised free-play ("modo libre") note FSM: converts an 8-bit ASCII key code into a note index with a count-enable for the tone generator. It generalises the four-key free mode to NUM_NOTES contiguous keys and adds a minimum-sound time, direct note-to-note switching, a per-note duration counter, and an end-of-note report for the scoring/recording logic. It sits between the keyboard decoder and the tone/timer blocks.

## Interface
- NUM_NOTES, 4, number of playable notes; legal 1..2^NOTE_W-1
- NOTE_W, 3, width of note index
- KEY_BASE, 8'd97, ASCII code of note 1; note k is key KEY_BASE+k-1; KEY_BASE+NUM_NOTES-1 <= 255
- MIN_HOLD, 4, minimum cycles a note sounds; 0 or 1 = release immediately
- DUR_W, 16, duration counter width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- inicio  in  1  arm free mode (sampled only in IDLE)
- fin  in  1  leave free mode, return to IDLE
- entrada  in  8  ASCII key code, level (held while key pressed)
- notaSalida  out  NOTE_W  current note 1..NUM_NOTES; 0 = silence
- contar  out  1  1 while a note sounds
- duracion  out  DUR_W  cycles current note has sounded, saturating
- nota_fin  out  1  one-cycle pulse when a note ends
- nota_fin_id  out  NOTE_W  note that ended (held until next nota_fin)
- nota_fin_dur  out  DUR_W  its final duracion (held until next nota_fin)

## Operation
- Valid key: KEY_BASE <= entrada <= KEY_BASE+NUM_NOTES-1; id = entrada-KEY_BASE+1 truncated to NOTE_W. All other codes are "no key".
- States: IDLE, ESPERA (armed, silent), SONANDO (key held), SOSTEN (key released, MIN_HOLD not yet met).
- IDLE: inicio=1 -> ESPERA; entrada ignored.
- ESPERA: valid key -> SONANDO, notaSalida<=id, contar<=1, duracion<=1.
- SONANDO/SOSTEN, evaluated per edge in this priority order:
  - fin=1 -> IDLE, end note (see below).
  - entrada == key of current note -> SONANDO, duracion increments.
  - other valid key -> SONANDO, end current note, notaSalida<=new id, duracion<=1, contar stays 1 (no silent gap).
  - no key and duracion >= MIN_HOLD -> ESPERA, end note, notaSalida<=0, contar<=0, duracion<=0.
  - no key and duracion < MIN_HOLD -> SOSTEN, duracion increments.
- ESPERA: fin=1 -> IDLE, no nota_fin.
- End note: nota_fin<=1 for one cycle, nota_fin_id<=current notaSalida, nota_fin_dur<=current duracion (value before the edge).
- duracion increments saturate at 2^DUR_W-1.
- IDLE/ESPERA: notaSalida=0, contar=0, duracion=0.
- Default/illegal state encoding -> IDLE.

## Timing
- All outputs registered; one-cycle latency: entrada sampled at edge k appears on notaSalida after edge k.
- Reset (highest priority, overrides fin): state IDLE, notaSalida=0, contar=0, duracion=0, nota_fin=0, nota_fin_id=0, nota_fin_dur=0. Reset mid-note produces no nota_fin.
- Key tapped for one cycle with MIN_HOLD=4: notaSalida nonzero for exactly 4 cycles; nota_fin asserted the cycle notaSalida returns to 0.
- Key held N >= MIN_HOLD cycles: note sounds N cycles, nota_fin_dur=N.
- SOSTEN re-press of same key resumes SONANDO without restarting duracion.
- fin and valid key on same edge: fin wins.
- inicio while not IDLE: ignored.

## Test plan
- Reset, inicio=0, entrada=97 for 5 cycles -> notaSalida=0, contar=0; pulse inicio, entrada=98 for 10 cycles then 0 -> notaSalida=2 for 10 cycles, duracion 1..10, nota_fin pulse with id=2, dur=10.
- Armed, entrada=99 for 1 cycle then 0 -> notaSalida=3, contar=1 for exactly 4 cycles; nota_fin id=3, dur=4.
- entrada=97 for 5 cycles then 100 for 3 cycles -> notaSalida 1 then 4 with no 0 cycle, contar stays 1; nota_fin id=1 dur=5, later id=4 dur=4 (MIN_HOLD).
- entrada=96 and 101 -> no note; rebuild with NUM_NOTES=7: entrada=103 -> notaSalida=7.
- fin during note 2 at duracion=6 -> next cycle notaSalida=0, contar=0, nota_fin id=2 dur=6; entrada=97 ignored until inicio.
- DUR_W=4, key held 20 cycles -> duracion stops at 15, nota_fin_dur=15; reset asserted mid-note -> all outputs 0 next edge, no nota_fin.
